// File: rtl/axis_packet_arbiter.sv
// axis_packet_arbiter
// Two-input, packet-level round-robin arbiter for AXI-Stream. A grant is held
// from the first beat to the tlast beat, so packets never interleave. The
// output stage is a single register slice (one cycle latency, full rate).
// A beat limit force-terminates packets from a producer that never sends tlast.
// Note: axis_aresetn is a synchronous, ACTIVE-HIGH reset despite its name.

module axis_packet_arbiter #(
  parameter int DATA_SIZE = 32,
  parameter int MAX_BEATS = 256,
  parameter int CNT_WIDTH = 16
) (
  input  logic                     axis_aclk,
  input  logic                     axis_aresetn,
  input  logic                     arb_enable,

  input  logic [DATA_SIZE-1:0]     s00_axis_tdata,
  input  logic [DATA_SIZE/8-1:0]   s00_axis_tstrb,
  input  logic                     s00_axis_tvalid,
  input  logic                     s00_axis_tlast,
  output logic                     s00_axis_tready,

  input  logic [DATA_SIZE-1:0]     s01_axis_tdata,
  input  logic [DATA_SIZE/8-1:0]   s01_axis_tstrb,
  input  logic                     s01_axis_tvalid,
  input  logic                     s01_axis_tlast,
  output logic                     s01_axis_tready,

  output logic [DATA_SIZE-1:0]     m00_axis_tdata,
  output logic [DATA_SIZE/8-1:0]   m00_axis_tstrb,
  output logic                     m00_axis_tvalid,
  output logic                     m00_axis_tlast,
  input  logic                     m00_axis_tready,

  output logic [1:0]               grant,
  output logic [CNT_WIDTH-1:0]     pkt_count0,
  output logic [CNT_WIDTH-1:0]     pkt_count1,
  output logic                     err_trunc
);

  localparam int BW = $clog2(MAX_BEATS + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BEATS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t                  state;
  state_t                  next_state;
  logic                    last_grant;
  logic [BW-1:0]           beat_cnt;

  logic                    out_free;
  logic                    sel_valid;
  logic                    sel_last;
  logic [DATA_SIZE-1:0]    sel_data;
  logic [DATA_SIZE/8-1:0]  sel_strb;
  logic                    accept;
  logic                    at_limit;
  logic                    pkt_end;
  logic                    trunc;

  assign grant = {state == GNT1, state == GNT0};

  // Select the granted input, derive ready and the beat-accept / packet-end events
  always_comb begin
    out_free        = !m00_axis_tvalid || m00_axis_tready;
    s00_axis_tready = (state == GNT0) && out_free;
    s01_axis_tready = (state == GNT1) && out_free;
    sel_valid       = 1'b0;
    sel_last        = 1'b0;
    sel_data        = s00_axis_tdata;
    sel_strb        = s00_axis_tstrb;
    if (state == GNT0) begin
      sel_valid = s00_axis_tvalid;
      sel_last  = s00_axis_tlast;
    end else if (state == GNT1) begin
      sel_valid = s01_axis_tvalid;
      sel_last  = s01_axis_tlast;
      sel_data  = s01_axis_tdata;
      sel_strb  = s01_axis_tstrb;
    end
    accept   = sel_valid && out_free;
    at_limit = (beat_cnt == LAST_BEAT);
    pkt_end  = accept && (sel_last || at_limit);
    trunc    = accept && !sel_last && at_limit;
  end

  // Next-state logic: round-robin pick in IDLE, hold the grant until packet end
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (arb_enable) begin
          if (s00_axis_tvalid && s01_axis_tvalid) begin
            next_state = last_grant ? GNT0 : GNT1;
          end else if (s00_axis_tvalid) begin
            next_state = GNT0;
          end else if (s01_axis_tvalid) begin
            next_state = GNT1;
          end
        end
      end
      GNT0, GNT1: begin
        if (pkt_end) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge axis_aclk) begin
    if (axis_aresetn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Output register slice, beat/packet counters, round-robin memory and error pulse
  always_ff @(posedge axis_aclk) begin
    if (axis_aresetn) begin
      m00_axis_tdata  <= '0;
      m00_axis_tstrb  <= '0;
      m00_axis_tvalid <= 1'b0;
      m00_axis_tlast  <= 1'b0;
      beat_cnt        <= '0;
      last_grant      <= 1'b1;
      pkt_count0      <= '0;
      pkt_count1      <= '0;
      err_trunc       <= 1'b0;
    end else begin
      err_trunc <= trunc;
      if (accept) begin
        m00_axis_tdata  <= sel_data;
        m00_axis_tstrb  <= sel_strb;
        m00_axis_tvalid <= 1'b1;
        m00_axis_tlast  <= sel_last || at_limit;
      end else if (m00_axis_tready) begin
        m00_axis_tvalid <= 1'b0;
      end
      if (pkt_end) begin
        beat_cnt <= '0;
      end else if (accept) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
      if (pkt_end) begin
        last_grant <= (state == GNT1);
        if (state == GNT1) begin
          pkt_count1 <= pkt_count1 + 1'b1;
        end else begin
          pkt_count0 <= pkt_count0 + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// tb_axis_packet_arbiter
// Directed bench: a per-cycle vector table for single-source and tie-break
// behaviour, plus queue-driven sequences for fairness, backpressure,
// truncation and enable/reset. The DUT runs with MAX_BEATS=4.

module tb_axis_packet_arbiter;

  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int CW = 16;
  localparam int MB = 4;

  logic           axis_aclk;
  logic           axis_aresetn;
  logic           arb_enable;
  logic [DW-1:0]  s00_axis_tdata;
  logic [SW-1:0]  s00_axis_tstrb;
  logic           s00_axis_tvalid;
  logic           s00_axis_tlast;
  logic           s00_axis_tready;
  logic [DW-1:0]  s01_axis_tdata;
  logic [SW-1:0]  s01_axis_tstrb;
  logic           s01_axis_tvalid;
  logic           s01_axis_tlast;
  logic           s01_axis_tready;
  logic [DW-1:0]  m00_axis_tdata;
  logic [SW-1:0]  m00_axis_tstrb;
  logic           m00_axis_tvalid;
  logic           m00_axis_tlast;
  logic           m00_axis_tready;
  logic [1:0]     grant;
  logic [CW-1:0]  pkt_count0;
  logic [CW-1:0]  pkt_count1;
  logic           err_trunc;

  axis_packet_arbiter #(.DATA_SIZE(DW), .MAX_BEATS(MB), .CNT_WIDTH(CW)) dut (
    .axis_aclk       (axis_aclk),
    .axis_aresetn    (axis_aresetn),
    .arb_enable      (arb_enable),
    .s00_axis_tdata  (s00_axis_tdata),
    .s00_axis_tstrb  (s00_axis_tstrb),
    .s00_axis_tvalid (s00_axis_tvalid),
    .s00_axis_tlast  (s00_axis_tlast),
    .s00_axis_tready (s00_axis_tready),
    .s01_axis_tdata  (s01_axis_tdata),
    .s01_axis_tstrb  (s01_axis_tstrb),
    .s01_axis_tvalid (s01_axis_tvalid),
    .s01_axis_tlast  (s01_axis_tlast),
    .s01_axis_tready (s01_axis_tready),
    .m00_axis_tdata  (m00_axis_tdata),
    .m00_axis_tstrb  (m00_axis_tstrb),
    .m00_axis_tvalid (m00_axis_tvalid),
    .m00_axis_tlast  (m00_axis_tlast),
    .m00_axis_tready (m00_axis_tready),
    .grant           (grant),
    .pkt_count0      (pkt_count0),
    .pkt_count1      (pkt_count1),
    .err_trunc       (err_trunc)
  );

  // Free-running clock, 10 time units per cycle
  initial axis_aclk = 1'b0;
  always #5 axis_aclk = ~axis_aclk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic          last;
  } beat_t;

  typedef struct {
    logic          tv0;
    logic [DW-1:0] d0;
    logic          l0;
    logic          tv1;
    logic [DW-1:0] d1;
    logic          l1;
    logic [1:0]    exp_grant;
    logic          exp_mv;
    logic [DW-1:0] exp_md;
    logic          exp_ml;
    logic          exp_rdy0;
    logic          exp_rdy1;
    logic [CW-1:0] exp_c0;
    logic [CW-1:0] exp_c1;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  beat_t src0[$];
  beat_t src1[$];
  beat_t out_q[$];
  beat_t exp_q[$];

  int            ready_mode;
  int            cyc;
  int            hs0_cnt, hs1_cnt, err_cnt;
  int            stab_viol, ready_viol, grant_viol;
  logic [DW-1:0] trunc_data;
  logic          trunc_last;
  logic          prev_mvalid, prev_mready, prev_mlast;
  logic [DW-1:0] prev_mdata;
  logic [1:0]    prev_grant;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic beat_t mk(input logic [DW-1:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.strb = ~d[3:0];
    b.last = l;
    return b;
  endfunction

  function automatic vec_t mkv(input logic tv0, input logic [DW-1:0] d0, input logic l0,
                               input logic tv1, input logic [DW-1:0] d1, input logic l1,
                               input logic [1:0] g, input logic mv, input logic [DW-1:0] md,
                               input logic ml, input logic r0, input logic r1,
                               input logic [CW-1:0] c0, input logic [CW-1:0] c1);
    vec_t v;
    v.tv0 = tv0; v.d0 = d0; v.l0 = l0;
    v.tv1 = tv1; v.d1 = d1; v.l1 = l1;
    v.exp_grant = g; v.exp_mv = mv; v.exp_md = md; v.exp_ml = ml;
    v.exp_rdy0 = r0; v.exp_rdy1 = r1; v.exp_c0 = c0; v.exp_c1 = c1;
    return v;
  endfunction

  task automatic drive_idle();
    s00_axis_tvalid = 1'b0; s00_axis_tdata = '0; s00_axis_tstrb = '0; s00_axis_tlast = 1'b0;
    s01_axis_tvalid = 1'b0; s01_axis_tdata = '0; s01_axis_tstrb = '0; s01_axis_tlast = 1'b0;
  endtask

  task automatic clear_stats();
    src0.delete(); src1.delete(); out_q.delete(); exp_q.delete();
    hs0_cnt = 0; hs1_cnt = 0; err_cnt = 0;
    stab_viol = 0; ready_viol = 0; grant_viol = 0;
    trunc_data = '0; trunc_last = 1'b0;
    prev_mvalid = 1'b0; prev_mready = 1'b0; prev_mlast = 1'b0;
    prev_mdata = '0; prev_grant = 2'b00;
    cyc = 0;
  endtask

  task automatic doReset(input bit check_state);
    @(negedge axis_aclk);
    axis_aresetn = 1'b1;
    arb_enable = 1'b1;
    m00_axis_tready = 1'b1;
    drive_idle();
    repeat (2) @(negedge axis_aclk);
    axis_aresetn = 1'b0;
    #1;
    clear_stats();
    if (check_state) begin
      checkOutput("reset_grant", grant, 2'b00);
      checkOutput("reset_mvalid", m00_axis_tvalid, 1'b0);
      checkOutput("reset_mdata", m00_axis_tdata, 32'h0);
      checkOutput("reset_mstrb", m00_axis_tstrb, 4'h0);
      checkOutput("reset_mlast", m00_axis_tlast, 1'b0);
      checkOutput("reset_rdy0", s00_axis_tready, 1'b0);
      checkOutput("reset_rdy1", s01_axis_tready, 1'b0);
      checkOutput("reset_cnt0", pkt_count0, 16'h0);
      checkOutput("reset_cnt1", pkt_count1, 16'h0);
      checkOutput("reset_err", err_trunc, 1'b0);
    end
  endtask

  // One table row: drive at the falling edge, compare just after it
  task automatic applyStimulus(input vec_t v, input int idx);
    @(negedge axis_aclk);
    s00_axis_tvalid = v.tv0; s00_axis_tdata = v.d0; s00_axis_tlast = v.l0; s00_axis_tstrb = 4'hA;
    s01_axis_tvalid = v.tv1; s01_axis_tdata = v.d1; s01_axis_tlast = v.l1; s01_axis_tstrb = 4'hA;
    m00_axis_tready = 1'b1;
    #1;
    checkOutput($sformatf("row%0d_grant", idx), grant, v.exp_grant);
    checkOutput($sformatf("row%0d_mvalid", idx), m00_axis_tvalid, v.exp_mv);
    checkOutput($sformatf("row%0d_rdy0", idx), s00_axis_tready, v.exp_rdy0);
    checkOutput($sformatf("row%0d_rdy1", idx), s01_axis_tready, v.exp_rdy1);
    checkOutput($sformatf("row%0d_cnt0", idx), pkt_count0, v.exp_c0);
    checkOutput($sformatf("row%0d_cnt1", idx), pkt_count1, v.exp_c1);
    checkOutput($sformatf("row%0d_err", idx), err_trunc, 1'b0);
    if (v.exp_mv) begin
      checkOutput($sformatf("row%0d_mdata", idx), m00_axis_tdata, v.exp_md);
      checkOutput($sformatf("row%0d_mlast", idx), m00_axis_tlast, v.exp_ml);
      checkOutput($sformatf("row%0d_mstrb", idx), m00_axis_tstrb, 4'hA);
    end
  endtask

  // One queue-driven cycle: present head beats, predict handshakes, watch invariants
  task automatic stream_cycle();
    @(negedge axis_aclk);
    drive_idle();
    if (src0.size() > 0) begin
      s00_axis_tvalid = 1'b1; s00_axis_tdata = src0[0].data;
      s00_axis_tstrb = src0[0].strb; s00_axis_tlast = src0[0].last;
    end
    if (src1.size() > 0) begin
      s01_axis_tvalid = 1'b1; s01_axis_tdata = src1[0].data;
      s01_axis_tstrb = src1[0].strb; s01_axis_tlast = src1[0].last;
    end
    m00_axis_tready = (ready_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
    cyc++;
    #1;
    if (grant == 2'b11) grant_viol++;
    if (prev_grant != 2'b00 && grant != 2'b00 && grant != prev_grant) grant_viol++;
    if (prev_mvalid && !prev_mready) begin
      if (!m00_axis_tvalid || m00_axis_tdata !== prev_mdata || m00_axis_tlast !== prev_mlast) stab_viol++;
    end
    if (m00_axis_tvalid && !m00_axis_tready && (s00_axis_tready || s01_axis_tready)) ready_viol++;
    if (err_trunc) begin
      err_cnt++;
      trunc_data = m00_axis_tdata;
      trunc_last = m00_axis_tlast;
    end
    if (s00_axis_tvalid && s00_axis_tready) begin
      void'(src0.pop_front());
      hs0_cnt++;
    end
    if (s01_axis_tvalid && s01_axis_tready) begin
      void'(src1.pop_front());
      hs1_cnt++;
    end
    if (m00_axis_tvalid && m00_axis_tready) out_q.push_back({m00_axis_tdata, m00_axis_tstrb, m00_axis_tlast});
    prev_mvalid = m00_axis_tvalid;
    prev_mready = m00_axis_tready;
    prev_mdata  = m00_axis_tdata;
    prev_mlast  = m00_axis_tlast;
    prev_grant  = grant;
  endtask

  task automatic run_stream(input string tag, input int budget);
    int k;
    k = 0;
    while (!(src0.size() == 0 && src1.size() == 0 && out_q.size() >= exp_q.size() && !m00_axis_tvalid)
           && k < budget) begin
      stream_cycle();
      k++;
    end
    checkOutput({tag, "_timeout"}, k < budget, 1'b1);
    checkOutput({tag, "_count"}, out_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      checkOutput($sformatf("%s_data%0d", tag, i), out_q[i].data, exp_q[i].data);
      checkOutput($sformatf("%s_strb%0d", tag, i), out_q[i].strb, exp_q[i].strb);
      checkOutput($sformatf("%s_last%0d", tag, i), out_q[i].last, exp_q[i].last);
    end
    checkOutput({tag, "_grant_rules"}, grant_viol, 0);
    checkOutput({tag, "_stable"}, stab_viol, 0);
    checkOutput({tag, "_ready_blocked"}, ready_viol, 0);
  endtask

  // Global time limit so the bench can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "[TB] watchdog");
  end

  // Main test sequence
  initial begin
    vec_t vecs[12];
    int   gnz, k, mv_cnt;

    axis_aresetn = 1'b1;
    arb_enable = 1'b1;
    m00_axis_tready = 1'b1;
    ready_mode = 0;
    drive_idle();
    clear_stats();

    vecs[0]  = mkv(1, 32'h11, 0, 0, 32'h0,  0, 2'b00, 0, 32'h0,  0, 0, 0, 16'd0, 16'd0);
    vecs[1]  = mkv(1, 32'h11, 0, 0, 32'h0,  0, 2'b01, 0, 32'h0,  0, 1, 0, 16'd0, 16'd0);
    vecs[2]  = mkv(1, 32'h12, 0, 0, 32'h0,  0, 2'b01, 1, 32'h11, 0, 1, 0, 16'd0, 16'd0);
    vecs[3]  = mkv(1, 32'h13, 0, 0, 32'h0,  0, 2'b01, 1, 32'h12, 0, 1, 0, 16'd0, 16'd0);
    vecs[4]  = mkv(1, 32'h14, 1, 0, 32'h0,  0, 2'b01, 1, 32'h13, 0, 1, 0, 16'd0, 16'd0);
    vecs[5]  = mkv(0, 32'h0,  0, 0, 32'h0,  0, 2'b00, 1, 32'h14, 1, 0, 0, 16'd1, 16'd0);
    vecs[6]  = mkv(0, 32'h0,  0, 0, 32'h0,  0, 2'b00, 0, 32'h0,  0, 0, 0, 16'd1, 16'd0);
    vecs[7]  = mkv(1, 32'h21, 1, 1, 32'h31, 1, 2'b00, 0, 32'h0,  0, 0, 0, 16'd1, 16'd0);
    vecs[8]  = mkv(1, 32'h21, 1, 1, 32'h31, 1, 2'b10, 0, 32'h0,  0, 0, 1, 16'd1, 16'd0);
    vecs[9]  = mkv(1, 32'h21, 1, 0, 32'h0,  0, 2'b00, 1, 32'h31, 1, 0, 0, 16'd1, 16'd1);
    vecs[10] = mkv(1, 32'h21, 1, 0, 32'h0,  0, 2'b01, 0, 32'h0,  0, 1, 0, 16'd1, 16'd1);
    vecs[11] = mkv(0, 32'h0,  0, 0, 32'h0,  0, 2'b00, 1, 32'h21, 1, 0, 0, 16'd2, 16'd1);

    $display("[TB] reset state and single-source table");
    doReset(1'b1);
    for (int i = 0; i < 12; i++) applyStimulus(vecs[i], i);

    $display("[TB] fairness: two continuous 3-beat producers");
    doReset(1'b0);
    for (int p = 0; p < 2; p++) begin
      for (int b = 0; b < 3; b++) begin
        src0.push_back(mk(32'hA1 + 32'(p * 3 + b), b == 2));
        src1.push_back(mk(32'hB1 + 32'(p * 3 + b), b == 2));
      end
    end
    for (int p = 0; p < 2; p++) begin
      for (int b = 0; b < 3; b++) exp_q.push_back(mk(32'hA1 + 32'(p * 3 + b), b == 2));
      for (int b = 0; b < 3; b++) exp_q.push_back(mk(32'hB1 + 32'(p * 3 + b), b == 2));
    end
    run_stream("fair", 200);
    checkOutput("fair_cnt0", pkt_count0, 16'd2);
    checkOutput("fair_cnt1", pkt_count1, 16'd2);
    checkOutput("fair_err", err_cnt, 0);

    $display("[TB] backpressure: s01 5 beats, downstream ready 1,0,0 repeating");
    doReset(1'b0);
    ready_mode = 1;
    for (int b = 0; b < 5; b++) src1.push_back(mk(32'hB1 + 32'(b), b == 4));
    for (int b = 0; b < 5; b++) exp_q.push_back(mk(32'hB1 + 32'(b), b >= 3));
    run_stream("bp", 200);
    checkOutput("bp_cnt1", pkt_count1, 16'd2);
    checkOutput("bp_cnt0", pkt_count0, 16'd0);
    checkOutput("bp_err", err_cnt, 1);
    ready_mode = 0;

    $display("[TB] truncation: s00 6 beats, limit 4");
    doReset(1'b0);
    for (int b = 0; b < 6; b++) src0.push_back(mk(32'hC1 + 32'(b), b == 5));
    for (int b = 0; b < 6; b++) exp_q.push_back(mk(32'hC1 + 32'(b), b == 3 || b == 5));
    run_stream("trunc", 200);
    checkOutput("trunc_err_pulses", err_cnt, 1);
    checkOutput("trunc_err_data", trunc_data, 32'hC4);
    checkOutput("trunc_err_last", trunc_last, 1'b1);
    checkOutput("trunc_cnt0", pkt_count0, 16'd2);

    $display("[TB] enable gating then reset mid-packet");
    clear_stats();
    arb_enable = 1'b0;
    for (int b = 0; b < 4; b++) begin
      src0.push_back(mk(32'hD1 + 32'(b), b == 3));
      src1.push_back(mk(32'hE1 + 32'(b), b == 3));
    end
    gnz = 0;
    mv_cnt = 0;
    repeat (10) begin
      stream_cycle();
      if (grant != 2'b00) gnz++;
      if (m00_axis_tvalid) mv_cnt++;
    end
    checkOutput("disabled_grant", gnz, 0);
    checkOutput("disabled_handshakes", hs0_cnt + hs1_cnt, 0);
    checkOutput("disabled_mvalid", mv_cnt, 0);
    arb_enable = 1'b1;
    k = 0;
    while (hs1_cnt < 2 && hs0_cnt == 0 && k < 20) begin
      stream_cycle();
      k++;
    end
    checkOutput("enable_timeout", k < 20, 1'b1);
    checkOutput("enable_winner_s01", hs1_cnt, 2);
    checkOutput("enable_loser_s00", hs0_cnt, 0);
    @(negedge axis_aclk);
    axis_aresetn = 1'b1;
    #1;
    checkOutput("prereset_mvalid", m00_axis_tvalid, 1'b1);
    checkOutput("prereset_mdata", m00_axis_tdata, 32'hE2);
    checkOutput("prereset_cnt0", pkt_count0, 16'd2);
    @(negedge axis_aclk);
    #1;
    checkOutput("midreset_mvalid", m00_axis_tvalid, 1'b0);
    checkOutput("midreset_mlast", m00_axis_tlast, 1'b0);
    checkOutput("midreset_grant", grant, 2'b00);
    checkOutput("midreset_cnt0", pkt_count0, 16'd0);
    checkOutput("midreset_cnt1", pkt_count1, 16'd0);
    checkOutput("midreset_err", err_trunc, 1'b0);
    checkOutput("midreset_rdy1", s01_axis_tready, 1'b0);
    drive_idle();
    axis_aresetn = 1'b0;
    clear_stats();
    mv_cnt = 0;
    repeat (5) begin
      stream_cycle();
      if (m00_axis_tvalid) mv_cnt++;
    end
    checkOutput("postreset_no_output", mv_cnt, 0);
    checkOutput("postreset_grant", grant, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
